// File: rtl/genie_pkg.sv
// rtl/genie_pkg.sv - shared widths, client ids and helpers for the Genie memory arbiter
package genie_pkg;

  localparam int GENIE_ADDR_W = 26;
  localparam int GENIE_DATA_W = 32;
  localparam int GENIE_OUTST  = 8;

  // Client ids follow the layer type encoding used by the engines
  typedef enum logic [1:0] {
    CID_CONV = 2'd0,
    CID_FC   = 2'd1,
    CID_POOL = 2'd2,
    CID_ACT  = 2'd3
  } genie_cid_e;

  // Next client after id, wrapping at n
  function automatic int genie_next_id(input int id, input int n);
    return (id + 1) % n;
  endfunction

endpackage

// File: rtl/genie_tag_fifo.sv
// rtl/genie_tag_fifo.sv - in-order tag FIFO with registered full/empty/count
module genie_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty_q;
  assign count_d = count_q + {{(CNT_W-1){1'b0}}, push_ok} - {{(CNT_W-1){1'b0}}, pop_ok};

  // Tag storage needs no reset; only pointers and flags define validity
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_data;
  end

  // Pointers, occupancy and flags, all registered so the arbiter gates on last cycle's state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  assign pop_data = mem_q[rptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;

endmodule

// File: rtl/genie_mem_arbiter.sv
// rtl/genie_mem_arbiter.sv - N-client memory arbiter, round-robin when GENIE_ARB_RR_EN is defined, else sel-driven
module genie_mem_arbiter
  import genie_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int ADDR_W    = GENIE_ADDR_W,
  parameter int DATA_W    = GENIE_DATA_W,
  parameter int OUTST     = GENIE_OUTST,
  localparam int CID_W    = $clog2(N_CLIENTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CID_W-1:0]              sel,
  input  logic [N_CLIENTS-1:0]          c_wvalid,
  output logic [N_CLIENTS-1:0]          c_wready,
  input  logic [N_CLIENTS*ADDR_W-1:0]   c_waddr,
  input  logic [N_CLIENTS*DATA_W-1:0]   c_wdata,
  input  logic [N_CLIENTS-1:0]          c_rvalid,
  output logic [N_CLIENTS-1:0]          c_rready,
  input  logic [N_CLIENTS*ADDR_W-1:0]   c_raddr,
  output logic [N_CLIENTS-1:0]          c_dvalid,
  output logic [DATA_W-1:0]             c_rdata,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  output logic [ADDR_W-1:0]             m_waddr,
  output logic [DATA_W-1:0]             m_wdata,
  output logic                          m_rvalid,
  input  logic                          m_rready,
  output logic [ADDR_W-1:0]             m_raddr,
  input  logic                          m_dvalid,
  input  logic [DATA_W-1:0]             m_rdata,
  output logic                          idle,
  output logic                          err_ret
);

  localparam logic [N_CLIENTS-1:0] ONE = {{(N_CLIENTS-1){1'b0}}, 1'b1};

  logic [CID_W-1:0]          gw, gr, head_tag;
  logic                      fifo_full, fifo_empty;
  logic [$clog2(OUTST):0]    fifo_count;
  logic                      w_xfer, rd_xfer, pop;
  logic                      err_ret_q;

`ifdef GENIE_ARB_RR_EN
  // Winner is the first requester at or after ptr, searching upward with wrap
  function automatic logic [CID_W-1:0] rr_pick(input logic [N_CLIENTS-1:0] req,
                                               input logic [CID_W-1:0]     ptr);
    logic [CID_W-1:0] win;
    win = ptr;
    for (int k = N_CLIENTS - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_CLIENTS]) win = CID_W'((int'(ptr) + k) % N_CLIENTS);
    end
    return win;
  endfunction

  logic [CID_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wlock_id_q, rlock_id_q;
  logic             wlock_q, rlock_q;

  assign gw     = wlock_q ? wlock_id_q : rr_pick(c_wvalid, wptr_q);
  assign gr     = rlock_q ? rlock_id_q : rr_pick(c_rvalid, rptr_q);
  assign wptr_d = w_xfer  ? CID_W'(genie_next_id(int'(gw), N_CLIENTS)) : wptr_q;
  assign rptr_d = rd_xfer ? CID_W'(genie_next_id(int'(gr), N_CLIENTS)) : rptr_q;

  // Pointers move past each winner; an unaccepted valid pins its grant for the next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      wlock_q    <= 1'b0;
      rlock_q    <= 1'b0;
      wlock_id_q <= '0;
      rlock_id_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      wlock_q    <= c_wvalid[gw] & ~w_xfer;
      rlock_q    <= c_rvalid[gr] & ~rd_xfer;
      wlock_id_q <= gw;
      rlock_id_q <= gr;
    end
  end
`else
  assign gw = sel;
  assign gr = sel;
`endif

  // Write channel: straight mux from the granted client, zero added latency
  assign m_wvalid = rst_n & c_wvalid[gw];
  assign m_waddr  = c_waddr[int'(gw)*ADDR_W +: ADDR_W];
  assign m_wdata  = c_wdata[int'(gw)*DATA_W +: DATA_W];
  assign c_wready = (rst_n & m_wready) ? (ONE << gw) : '0;
  assign w_xfer   = m_wvalid & m_wready;

  // Read request channel, throttled by the registered tag FIFO full flag
  assign m_rvalid = rst_n & c_rvalid[gr] & ~fifo_full;
  assign m_raddr  = c_raddr[int'(gr)*ADDR_W +: ADDR_W];
  assign c_rready = (rst_n & m_rready & ~fifo_full) ? (ONE << gr) : '0;
  assign rd_xfer  = m_rvalid & m_rready;

  // Returned data goes only to the client at the FIFO head
  assign pop      = rst_n & m_dvalid & ~fifo_empty;
  assign c_dvalid = pop ? (ONE << head_tag) : '0;
  assign c_rdata  = m_rdata;

  genie_tag_fifo #(
    .WIDTH (CID_W),
    .DEPTH (OUTST)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_xfer),
    .push_data (gr),
    .pop       (pop),
    .pop_data  (head_tag),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A return with nothing outstanding is a protocol error that sticks until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       err_ret_q <= 1'b0;
    else if (m_dvalid && fifo_empty)  err_ret_q <= 1'b1;
  end

  assign err_ret = err_ret_q;
  assign idle    = (fifo_count == '0);

endmodule

// File: tb/tb_genie_mem_arbiter.sv
// tb/tb_genie_mem_arbiter.sv - randomized self-checking bench for genie_mem_arbiter
module tb_genie_mem_arbiter;
  import genie_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 26;
  localparam int DW  = 32;
  localparam int OUT = 8;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] sel;
  logic [N-1:0]  c_wvalid, c_wready, c_rvalid, c_rready, c_dvalid;
  logic [N*AW-1:0] c_waddr, c_raddr;
  logic [N*DW-1:0] c_wdata;
  logic [DW-1:0] c_rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_waddr, m_raddr;
  logic          m_wvalid, m_wready, m_rvalid, m_rready, m_dvalid;
  logic          idle, err_ret;

  int errors = 0;
  int checks = 0;
  int tagq[$];
  bit err_exp;

  always #5 clk = ~clk;

  genie_mem_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .OUTST(OUT)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel),
    .c_wvalid(c_wvalid), .c_wready(c_wready), .c_waddr(c_waddr), .c_wdata(c_wdata),
    .c_rvalid(c_rvalid), .c_rready(c_rready), .c_raddr(c_raddr),
    .c_dvalid(c_dvalid), .c_rdata(c_rdata),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_waddr(m_waddr), .m_wdata(m_wdata),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_raddr(m_raddr),
    .m_dvalid(m_dvalid), .m_rdata(m_rdata),
    .idle(idle), .err_ret(err_ret)
  );

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      c_waddr[i*AW +: AW] = AW'($urandom);
      c_raddr[i*AW +: AW] = AW'($urandom);
      c_wdata[i*DW +: DW] = $urandom;
    end
    m_rdata = $urandom;
  endtask

  task automatic quiet_inputs();
    c_wvalid = '0; c_rvalid = '0;
    m_wready = 0;  m_rready = 0; m_dvalid = 0;
    rand_payload();
  endtask

  // Model of the outstanding-read bookkeeping: in-order list of issuing clients,
  // updated from the inputs the DUT sees at this clock edge (sel-driven grant).
  task automatic tick();
    bit push;
    push = c_rvalid[sel] && m_rready && (tagq.size() < OUT);
    if (m_dvalid) begin
      if (tagq.size() > 0) void'(tagq.pop_front());
      else err_exp = 1;
    end
    if (push) tagq.push_back(int'(sel));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; sel = 0;
    rand_payload();
    c_wvalid = '1; c_rvalid = '1; m_wready = 1; m_rready = 1; m_dvalid = 1;
    #3;
    checks++; if (m_wvalid !== 1'b0) begin errors++; $display("FAIL reset_m_wvalid got=%b exp=0", m_wvalid); end
    checks++; if (c_wready !== 4'b0) begin errors++; $display("FAIL reset_c_wready got=%b exp=0000", c_wready); end
    checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL reset_m_rvalid got=%b exp=0", m_rvalid); end
    checks++; if (c_rready !== 4'b0) begin errors++; $display("FAIL reset_c_rready got=%b exp=0000", c_rready); end
    checks++; if (c_dvalid !== 4'b0) begin errors++; $display("FAIL reset_c_dvalid got=%b exp=0000", c_dvalid); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", idle); end
    checks++; if (err_ret !== 1'b0) begin errors++; $display("FAIL reset_err_ret got=%b exp=0", err_ret); end
    quiet_inputs();
    tagq.delete(); err_exp = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_sel();
    sel = 1;
    for (int k = 0; k < 3; k++) begin
      rand_payload();
      c_wvalid = 4'b0011; m_wready = 1;
      @(negedge clk);
      checks++; if (m_wvalid !== 1'b1) begin errors++; $display("FAIL t1_m_wvalid[%0d] got=%b exp=1", k, m_wvalid); end
      checks++; if (m_waddr !== c_waddr[AW +: AW]) begin errors++; $display("FAIL t1_waddr[%0d] got=%h exp=%h", k, m_waddr, c_waddr[AW +: AW]); end
      checks++; if (m_wdata !== c_wdata[DW +: DW]) begin errors++; $display("FAIL t1_wdata[%0d] got=%h exp=%h", k, m_wdata, c_wdata[DW +: DW]); end
      checks++; if (c_wready !== 4'b0010) begin errors++; $display("FAIL t1_c_wready[%0d] got=%b exp=0010", k, c_wready); end
      tick();
    end
    c_wvalid = 4'b0001;
    @(negedge clk);
    checks++; if (m_wvalid !== 1'b0) begin errors++; $display("FAIL t1_client0_ignored got=%b exp=0", m_wvalid); end
    tick();
    quiet_inputs();
  endtask

  task automatic test_write_stall();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    sel = 2;
    rand_payload();
    a = c_waddr[2*AW +: AW]; d = c_wdata[2*DW +: DW];
    c_wvalid = 4'b1111; m_wready = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (m_wvalid !== 1'b1 || m_waddr !== a) begin errors++; $display("FAIL t4_hold[%0d] got=%b/%h exp=1/%h", k, m_wvalid, m_waddr, a); end
      checks++; if (c_wready !== 4'b0) begin errors++; $display("FAIL t4_ready_low[%0d] got=%b exp=0000", k, c_wready); end
      tick();
    end
    m_wready = 1;
    @(negedge clk);
    checks++; if (c_wready !== 4'b0100 || m_wdata !== d) begin errors++; $display("FAIL t4_accept got=%b/%h exp=0100/%h", c_wready, m_wdata, d); end
    tick();
    quiet_inputs();
  endtask

  task automatic test_full();
    int acc = 0;
    sel = 3;
    c_rvalid = 4'b1111; m_rready = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_rvalid && m_rready) acc++;
      checks++; if (m_rvalid !== (tagq.size() < OUT)) begin errors++; $display("FAIL t3_m_rvalid[%0d] got=%b exp=%0b", k, m_rvalid, tagq.size() < OUT); end
      checks++; if (m_raddr !== c_raddr[3*AW +: AW]) begin errors++; $display("FAIL t3_raddr[%0d] got=%h exp=%h", k, m_raddr, c_raddr[3*AW +: AW]); end
      tick();
    end
    @(negedge clk);
    checks++; if (acc !== OUT) begin errors++; $display("FAIL t3_accepted got=%0d exp=%0d", acc, OUT); end
    checks++; if (idle !== 1'b0 || m_rvalid !== 1'b0) begin errors++; $display("FAIL t3_full_state idle/m_rvalid got=%b/%b exp=0/0", idle, m_rvalid); end
    m_dvalid = 1; m_rdata = $urandom;
    #1;
    checks++; if (c_dvalid !== 4'b1000 || c_rdata !== m_rdata) begin errors++; $display("FAIL t3_pop got=%b/%h exp=1000/%h", c_dvalid, c_rdata, m_rdata); end
    checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL t3_push_blocked got=%b exp=0", m_rvalid); end
    tick();
    m_dvalid = 0;
    @(negedge clk);
    checks++; if (m_rvalid !== 1'b1) begin errors++; $display("FAIL t3_slot_freed got=%b exp=1", m_rvalid); end
    tick();
    c_rvalid = '0; m_dvalid = 1;
    for (int k = 0; k < OUT; k++) begin
      m_rdata = $urandom;
      @(negedge clk);
      checks++; if (c_dvalid !== 4'b1000 || c_rdata !== m_rdata) begin errors++; $display("FAIL t3_drain[%0d] got=%b/%h exp=1000/%h", k, c_dvalid, c_rdata, m_rdata); end
      tick();
    end
    m_dvalid = 0;
    @(negedge clk);
    checks++; if (idle !== 1'b1 || err_ret !== 1'b0) begin errors++; $display("FAIL t3_drained idle/err got=%b/%b exp=1/0", idle, err_ret); end
    quiet_inputs();
  endtask

  task automatic test_random();
    bit whold, rhold;
    logic [N-1:0] exp_w, exp_r, exp_d;
    bit full;
    for (int s = 0; s < N; s++) begin
      sel = CW'(s);
      whold = 0; rhold = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
        if (!whold) begin
          c_wvalid = N'($urandom);
          for (int i = 0; i < N; i++) begin
            c_waddr[i*AW +: AW] = AW'($urandom);
            c_wdata[i*DW +: DW] = $urandom;
          end
        end
        if (!rhold) begin
          c_rvalid = N'($urandom);
          for (int i = 0; i < N; i++) c_raddr[i*AW +: AW] = AW'($urandom);
        end
        m_wready = 1'($urandom);
        m_rready = 1'($urandom);
        m_dvalid = (tagq.size() > 0) && ($urandom_range(0, 2) == 0);
        m_rdata  = $urandom;
        full  = (tagq.size() == OUT);
        exp_w = m_wready ? (N'(1) << s) : '0;
        exp_r = (m_rready && !full) ? (N'(1) << s) : '0;
        exp_d = (m_dvalid && tagq.size() > 0) ? (N'(1) << tagq[0]) : '0;
        @(negedge clk);
        checks++; if (m_wvalid !== c_wvalid[s] || c_wready !== exp_w) begin errors++; $display("FAIL rnd_write s=%0d c=%0d got=%b/%b exp=%b/%b", s, cyc, m_wvalid, c_wready, c_wvalid[s], exp_w); end
        checks++; if (m_waddr !== c_waddr[s*AW +: AW] || m_wdata !== c_wdata[s*DW +: DW]) begin errors++; $display("FAIL rnd_wpath s=%0d c=%0d got=%h/%h", s, cyc, m_waddr, m_wdata); end
        checks++; if (m_rvalid !== (c_rvalid[s] && !full) || c_rready !== exp_r) begin errors++; $display("FAIL rnd_read s=%0d c=%0d got=%b/%b exp=%b/%b", s, cyc, m_rvalid, c_rready, c_rvalid[s] && !full, exp_r); end
        checks++; if (m_raddr !== c_raddr[s*AW +: AW]) begin errors++; $display("FAIL rnd_raddr s=%0d c=%0d got=%h exp=%h", s, cyc, m_raddr, c_raddr[s*AW +: AW]); end
        checks++; if (c_dvalid !== exp_d || (m_dvalid && c_rdata !== m_rdata)) begin errors++; $display("FAIL rnd_return s=%0d c=%0d got=%b/%h exp=%b/%h", s, cyc, c_dvalid, c_rdata, exp_d, m_rdata); end
        checks++; if (idle !== (tagq.size() == 0)) begin errors++; $display("FAIL rnd_idle s=%0d c=%0d got=%b exp=%0b", s, cyc, idle, tagq.size() == 0); end
        whold = c_wvalid[s] && !m_wready;
        rhold = c_rvalid[s] && !(m_rready && !full);
        tick();
      end
      c_wvalid = '0; c_rvalid = '0; m_dvalid = 1;
      for (int k = 0; k < OUT + 2 && tagq.size() > 0; k++) begin
        exp_d = N'(1) << tagq[0];
        @(negedge clk);
        checks++; if (c_dvalid !== exp_d) begin errors++; $display("FAIL rnd_drain s=%0d got=%b exp=%b", s, c_dvalid, exp_d); end
        tick();
      end
      m_dvalid = 0;
      @(negedge clk);
      checks++; if (idle !== 1'b1 || err_ret !== 1'b0) begin errors++; $display("FAIL rnd_end s=%0d idle/err got=%b/%b exp=1/0", s, idle, err_ret); end
      tick();
    end
    quiet_inputs();
  endtask

  task automatic test_rr_order();
    logic [N-1:0] exp;
    sel = 0;
    rand_payload();
    c_rvalid = 4'b1111; m_rready = 1;
    for (int k = 0; k < 5; k++) begin
      exp = N'(1) << (k % N);
      @(negedge clk);
      checks++; if (c_rready !== exp || m_raddr !== c_raddr[(k%N)*AW +: AW]) begin errors++; $display("FAIL t2_grant[%0d] got=%b/%h exp=%b/%h", k, c_rready, m_raddr, exp, c_raddr[(k%N)*AW +: AW]); end
      tick();
    end
    c_rvalid = '0; m_rready = 0; m_dvalid = 1;
    for (int k = 0; k < 5; k++) begin
      exp = N'(1) << (k % N);
      m_rdata = $urandom;
      @(negedge clk);
      checks++; if (c_dvalid !== exp || c_rdata !== m_rdata) begin errors++; $display("FAIL t2_return[%0d] got=%b/%h exp=%b/%h", k, c_dvalid, c_rdata, exp, m_rdata); end
      tick();
    end
    quiet_inputs();
  endtask

  task automatic test_err_ret();
    m_dvalid = 1;
    @(negedge clk);
    checks++; if (c_dvalid !== 4'b0) begin errors++; $display("FAIL t5_no_dvalid got=%b exp=0000", c_dvalid); end
    tick();
    m_dvalid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (err_ret !== err_exp || err_ret !== 1'b1) begin errors++; $display("FAIL t5_sticky[%0d] got=%b exp=1", k, err_ret); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    rand_payload();
    c_rvalid = 4'b0001; m_rready = 1;
    for (int k = 0; k < 3; k++) tick();
    c_wvalid = 4'b0001; m_wready = 1;
    @(negedge clk);
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL t6_busy got=%b exp=0", idle); end
    #2 rst_n = 0;
    #1;
    checks++; if (m_rvalid !== 1'b0 || c_rready !== 4'b0 || m_wvalid !== 1'b0 || c_wready !== 4'b0) begin errors++; $display("FAIL t6_async_outputs got=%b/%b/%b/%b exp=0/0000/0/0000", m_rvalid, c_rready, m_wvalid, c_wready); end
    checks++; if (err_ret !== 1'b0) begin errors++; $display("FAIL t6_err_cleared got=%b exp=0", err_ret); end
    tagq.delete(); err_exp = 0;
    quiet_inputs();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL t6_idle_after got=%b exp=1", idle); end
    m_dvalid = 1;
    tick();
    m_dvalid = 0;
    @(negedge clk);
    checks++; if (err_ret !== err_exp || err_ret !== 1'b1) begin errors++; $display("FAIL t6_late_return got=%b exp=1", err_ret); end
    tick();
  endtask

  initial begin
    quiet_inputs();
    test_reset();
`ifdef GENIE_ARB_RR_EN
    test_rr_order();
`else
    test_write_sel();
    test_write_stall();
    test_full();
    test_random();
`endif
    test_err_ret();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end

endmodule
